// File: rtl/rr_arbiter_demux.sv
// Round-robin arbiter over four show-ahead input FIFOs that routes each popped
// word to one of four output FIFOs chosen by the word's two MSBs.
module rr_arbiter_demux #(
  parameter int data_width = 10,
  parameter int cnt_width  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            fifo_empty,
  input  logic [data_width-1:0] fifo_data_in0,
  input  logic [data_width-1:0] fifo_data_in1,
  input  logic [data_width-1:0] fifo_data_in2,
  input  logic [data_width-1:0] fifo_data_in3,
  input  logic [3:0]            almost_full,
  output logic [3:0]            pop,
  output logic [3:0]            push,
  output logic [data_width-1:0] data_out,
  output logic                  idle,
  output logic [cnt_width-1:0]  cnt0,
  output logic [cnt_width-1:0]  cnt1,
  output logic [cnt_width-1:0]  cnt2,
  output logic [cnt_width-1:0]  cnt3
);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_ACTIVE
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            rr_ptr_q, rr_ptr_d;
  logic [3:0]            push_q, push_d;
  logic [data_width-1:0] data_q, data_d;
  logic [cnt_width-1:0]  cnt_q [4];
  logic [cnt_width-1:0]  cnt_d [4];

  logic [data_width-1:0] head [4];
  logic [3:0]            elig;
  logic                  any_elig;
  logic                  grant_valid;
  logic [1:0]            grant_idx;
  logic [1:0]            idx;
  logic [data_width-1:0] sel_word;
  logic [1:0]            sel_dest;

  always_comb begin
    head[0] = fifo_data_in0;
    head[1] = fifo_data_in1;
    head[2] = fifo_data_in2;
    head[3] = fifo_data_in3;
  end

  // An input counts only if its own destination has room; a blocked head is
  // skipped so it never stalls the other inputs.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      elig[i] = !fifo_empty[i] && !almost_full[head[i][data_width-1 -: 2]];
    end
    any_elig = |elig;
  end

  // NOTE: every combinational output gets a default before the search loop;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = rr_ptr_q;
    idx         = rr_ptr_q;
    if (state_q != ST_INIT) begin
      for (int k = 1; k <= 4; k++) begin
        idx = rr_ptr_q + 2'(k);
        if (!grant_valid && elig[idx]) begin
          grant_valid = 1'b1;
          grant_idx   = idx;
        end
      end
    end
  end

  assign sel_word = head[grant_idx];
  assign sel_dest = sel_word[data_width-1 -: 2];
  assign pop      = grant_valid ? (4'b0001 << grant_idx) : 4'b0000;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    push_d   = 4'b0000;
    data_d   = data_q;
    for (int i = 0; i < 4; i++) cnt_d[i] = cnt_q[i];

    case (state_q)
      ST_INIT:   state_d = ST_IDLE;
      ST_IDLE:   state_d = any_elig ? ST_ACTIVE : ST_IDLE;
      ST_ACTIVE: state_d = any_elig ? ST_ACTIVE : ST_IDLE;
      default:   state_d = ST_INIT;
    endcase

    if (grant_valid) begin
      rr_ptr_d        = grant_idx;
      push_d          = 4'b0001 << sel_dest;
      data_d          = sel_word;
      cnt_d[sel_dest] = cnt_q[sel_dest] + cnt_width'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values computed above regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_INIT;
      rr_ptr_q <= 2'd3;
      push_q   <= 4'b0000;
      data_q   <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      push_q   <= push_d;
      data_q   <= data_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign push     = push_q;
  assign data_out = data_q;
  assign idle     = (state_q == ST_IDLE);
  assign cnt0     = cnt_q[0];
  assign cnt1     = cnt_q[1];
  assign cnt2     = cnt_q[2];
  assign cnt3     = cnt_q[3];

endmodule

// File: tb/tb_rr_arbiter_demux.sv
// Directed and randomized checks of rr_arbiter_demux against a cycle-level
// behavioural model of the round-robin/demux rules.
module tb_rr_arbiter_demux;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] fifo_empty = 4'hF;
  logic [3:0] almost_full = 4'h0;
  logic [9:0] din [4];
  logic [3:0] pop, push;
  logic [9:0] data_out;
  logic       idle;
  logic [7:0] cnt0, cnt1, cnt2, cnt3;

  int total = 0;
  int bad   = 0;

  // Model state: pointer of last grant, whether we are in the post-reset
  // settle cycle, and expected registered outputs.
  int         m_ptr;
  bit         m_init;
  logic [3:0] m_push;
  logic [9:0] m_data;
  logic [7:0] m_cnt [4];
  logic       m_idle;

  rr_arbiter_demux #(.data_width(10), .cnt_width(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .fifo_empty   (fifo_empty),
    .fifo_data_in0(din[0]),
    .fifo_data_in1(din[1]),
    .fifo_data_in2(din[2]),
    .fifo_data_in3(din[3]),
    .almost_full  (almost_full),
    .pop          (pop),
    .push         (push),
    .data_out     (data_out),
    .idle         (idle),
    .cnt0         (cnt0),
    .cnt1         (cnt1),
    .cnt2         (cnt2),
    .cnt3         (cnt3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_elig(int i);
    return !fifo_empty[i] && !almost_full[din[i][9:8]];
  endfunction

  function automatic int model_grant();
    if (m_init) return -1;
    for (int k = 1; k <= 4; k++) begin
      if (is_elig((m_ptr + k) % 4)) return (m_ptr + k) % 4;
    end
    return -1;
  endfunction

  function automatic bit any_elig();
    return is_elig(0) || is_elig(1) || is_elig(2) || is_elig(3);
  endfunction

  task automatic check_regs(input string tag);
    check({tag, ".push"}, 32'(push), 32'(m_push));
    check({tag, ".data"}, 32'(data_out), 32'(m_data));
    check({tag, ".idle"}, 32'(idle), 32'(m_idle));
    check({tag, ".cnt0"}, 32'(cnt0), 32'(m_cnt[0]));
    check({tag, ".cnt1"}, 32'(cnt1), 32'(m_cnt[1]));
    check({tag, ".cnt2"}, 32'(cnt2), 32'(m_cnt[2]));
    check({tag, ".cnt3"}, 32'(cnt3), 32'(m_cnt[3]));
  endtask

  // Called just after a negedge with inputs already driven; returns at the
  // next negedge.
  task automatic step(input string tag);
    int  g;
    bit  any;
    #1;
    g   = model_grant();
    any = any_elig();
    check({tag, ".pop"}, 32'(pop), (g >= 0) ? (32'd1 << g) : 32'd0);
    @(posedge clk);
    if (g >= 0) begin
      m_push = 4'b0001 << din[g][9:8];
      m_data = din[g];
      m_cnt[din[g][9:8]] = m_cnt[din[g][9:8]] + 8'd1;
      m_ptr = g;
    end else begin
      m_push = 4'b0000;
    end
    m_idle = m_init ? 1'b1 : !any;
    m_init = 1'b0;
    #1;
    check_regs(tag);
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_ptr  = 3;
    m_init = 1'b1;
    m_push = 4'b0000;
    m_data = 10'h000;
    m_idle = 1'b0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 8'd0;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    model_reset();
    #1;
    check({tag, ".pop"}, 32'(pop), 32'd0);
    check_regs(tag);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) din[i] = 10'h000;
    @(negedge clk);

    // Test 1: single input, dest 0.
    do_reset("rst");
    fifo_empty = 4'b1110;
    din[0] = 10'b0010010000;
    step("t1.init");
    step("t1.grant");
    fifo_empty = 4'b1111;
    step("t1.push");
    check("t1.data_090", 32'(data_out), 32'h090);
    check("t1.cnt0_one", 32'(cnt0), 32'd1);

    // Test 2: all inputs busy, one per destination.
    for (int i = 0; i < 4; i++) din[i] = 10'((i << 8) | (i * 16 + 3));
    fifo_empty = 4'b0000;
    for (int c = 0; c < 9; c++) step("t2.rr");

    // Test 3: blocked head of FIFO1 must not stall FIFO2.
    din[1] = 10'h2A1;
    din[2] = 10'h3B2;
    fifo_empty = 4'b1001;
    almost_full = 4'b0100;
    for (int c = 0; c < 4; c++) step("t3.blocked");
    almost_full = 4'b0000;
    for (int c = 0; c < 2; c++) step("t3.released");

    // Test 4: drain to idle; data_out holds.
    fifo_empty = 4'b1111;
    for (int c = 0; c < 3; c++) step("t4.empty");

    // Test 5: reset during the grant cycle of 10'h155.
    din[1] = 10'h155;
    fifo_empty = 4'b1101;
    #1;
    check("t5.grant_seen", 32'(pop), 32'(4'b0010 << 0) << (model_grant() - 1));
    #1;
    do_reset("t5.rst");
    fifo_empty = 4'b1111;
    step("t5.init");
    step("t5.after");
    check("t5.no_155", 32'(data_out == 10'h155), 32'd0);
    din[3] = 10'h0C4;
    fifo_empty = 4'b0111;
    step("t5.first_pop");

    // Test 6: 257 words to dest 3 wraps cnt3.
    do_reset("t6.rst");
    din[0] = 10'h3FF;
    fifo_empty = 4'b1110;
    for (int c = 0; c < 258; c++) step("t6.wrap");
    check("t6.cnt3_wrap", 32'(cnt3), 32'd1);
    check("t6.cnt0_zero", 32'(cnt0), 32'd0);

    // Random traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) din[i] = 10'($urandom_range(0, 1023));
      fifo_empty  = 4'($urandom_range(0, 15));
      almost_full = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
